serial_tone_synth: RTL and testbench
====================================

# serial_tone_synth

Frame-serial sinusoid synthesiser: the inverse of the Goertzel single-bin analyser in the AC_PH cascade. It accepts one complex bin coefficient per channel (re, im; fixed point with WF fractional bits) plus the bin twiddle (cos ω, sin ω). It then emits FRAME_LENGTH real samples per channel, x[n] = re·cos(ωn) − im·sin(ωn), using the second-order recursion y[n] = 2cos ω·y[n−1] − y[n−2]. It is used as a reference-tone generator and as a round-trip checker for the analyser.

## Interface
- W_WIDTH, 16, twiddle width, signed, WF fractional bits
- X_WIDTH, 16, output sample width, signed integer
- S_WIDTH, 32, coefficient/state width, signed, WF fractional bits
- WF, 10, fractional bits of twiddles, coefficients and state
- FRAME_LENGTH, 3, samples per frame (≥2)
- CHANNELS, 2, parallel channels sharing twiddle and counter
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- w_re  in  W_WIDTH  cos ω, sampled on load handshake
- w_im  in  W_WIDTH  sin ω, sampled on load handshake
- valid_i  in  1  coefficient valid
- ready_o  out  1  block can accept coefficients
- re  in  CHANNELS×S_WIDTH  real coefficient per channel
- im  in  CHANNELS×S_WIDTH  imaginary coefficient per channel
- x  out  CHANNELS×X_WIDTH  current output sample per channel
- valid_o  out  1  x valid
- ready_i  in  1  downstream accepts x
- last_o  out  1  x is sample FRAME_LENGTH−1 of the frame

## Operation
- FSM states: IDLE, PRIME, RUN.
- IDLE: ready_o=1. On valid_i&ready_o, latch w_re, w_im, re→y_cur and im→tmp per channel. Clear cnt. Go to PRIME.
- PRIME: ready_o=0. Per channel, y_prev ← (re·w_re + im·w_im) >>> WF, which is y[−1]. Go to RUN.
- RUN: ready_o=0, valid_o=1, last_o=(cnt==FRAME_LENGTH−1).
- RUN handshake (valid_o&ready_i):
  - y_cur ← ((y_cur·(w_re<<1)) >>> WF) − y_prev
  - y_prev ← y_cur
  - cnt ← cnt+1
  - If last_o, go to IDLE instead and leave the state unchanged.
- RUN without handshake: all registers hold. x and last_o stay stable.
- x[i] = saturate(y_cur[i] >>> WF) to X_WIDTH. Clamp to [−2^(X_WIDTH−1), 2^(X_WIDTH−1)−1].
- Arithmetic:
  - Products are computed at full width (S_WIDTH+W_WIDTH+1) and arithmetic-shifted right by WF. The sum is formed before the shift.
  - Results are truncated to S_WIDTH (two's-complement wrap).
  - The caller keeps |re|+|im| < 2^(S_WIDTH−2). The state is not saturated.
- cnt width: $clog2(FRAME_LENGTH)+1. cnt never exceeds FRAME_LENGTH−1.
- Twiddle inputs may change freely after the load handshake. Only the latched copies are used.

## Timing
- Reset (rstn=0 at posedge): state=IDLE, cnt=0, y_cur=y_prev=0.
  - Outputs in the following cycle: ready_o=1, valid_o=0, last_o=0, x=0.
  - While rstn is low, ready_o=0.
- Reset mid-frame aborts the frame. No further valid_o until a new load.
- Latency: load accepted at edge T → PRIME in cycle T+1 → valid_o=1 with sample 0 from cycle T+2.
- With ready_i held high, one sample per cycle. The frame occupies FRAME_LENGTH+1 cycles after the load, including PRIME.
- The next load is accepted earliest in the cycle after the last_o handshake (ready_o=1 in IDLE). There is no overlap of load and output.
- valid_i while ready_o=0 is ignored. The upstream must hold its data.
- last_o is asserted only together with valid_o.

## Test plan
- Quarter-wave cosine: WF=10, FRAME_LENGTH=4, w_re=0, w_im=1024, re=102400 (100.0), im=0, ready_i=1 → x=100,0,−100,0. Sample 0 appears 2 cycles after load. last_o on the 4th sample only. ready_o returns 1 next cycle.
- Quarter-wave sine: same twiddle, re=0, im=51200 → x=0,−50,0,50 on consecutive cycles.
- DC and saturation: w_re=1024, w_im=0, FRAME_LENGTH=3.
  - re=7168 → x=7,7,7.
  - re=40960000 → x=32767 ×3.
  - re=−40960000 → x=−32768 ×3.
- Backpressure: quarter-wave cosine frame, ready_i=0 for 3 cycles while sample 1 is presented → x=0 and last_o=0 held stable with valid_o=1. Sequence resumes 0,−100,0 with no skipped or repeated sample.
- Handshake discipline:
  - valid_i pulsed during RUN with different re → ignored; the current frame is unaffected.
  - Back-to-back loads (valid_i held high) → the second frame starts exactly 2 cycles after the first frame's last handshake.
  - Both channels run independently (ch0 re=102400, ch1 im=51200) → correct per-channel sequences.
- Reset mid-frame: rstn=0 for 1 cycle after sample 1 → next cycle valid_o=0, x=0, ready_o=1. A new load then produces a clean, full frame.

Source files
------------

// File: rtl/serial_tone_synth.sv
// Frame-serial sinusoid synthesiser: rebuilds x[n] = re*cos(wn) - im*sin(wn) per channel
// from one complex bin coefficient, using the recursion y[n] = 2cos(w)*y[n-1] - y[n-2].
module serial_tone_synth #(
  parameter int W_WIDTH      = 16,
  parameter int X_WIDTH      = 16,
  parameter int S_WIDTH      = 32,
  parameter int WF           = 10,
  parameter int FRAME_LENGTH = 3,
  parameter int CHANNELS     = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [W_WIDTH-1:0]            w_re,
  input  logic [W_WIDTH-1:0]            w_im,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [CHANNELS*S_WIDTH-1:0]   re,
  input  logic [CHANNELS*S_WIDTH-1:0]   im,
  output logic [CHANNELS*X_WIDTH-1:0]   x,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          last_o
);

  localparam int CW = $clog2(FRAME_LENGTH) + 1;
  localparam int PW = S_WIDTH + W_WIDTH + 1;
  localparam int YW = S_WIDTH - WF;
  localparam logic signed [YW-1:0] XMAX = YW'((2 ** (X_WIDTH - 1)) - 1);
  localparam logic signed [YW-1:0] XMIN = YW'(-(2 ** (X_WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic signed [W_WIDTH-1:0]  wre_q, wre_d;
  logic signed [W_WIDTH-1:0]  wim_q, wim_d;
  logic signed [S_WIDTH-1:0]  y_cur_q  [CHANNELS];
  logic signed [S_WIDTH-1:0]  y_cur_d  [CHANNELS];
  logic signed [S_WIDTH-1:0]  y_prev_q [CHANNELS];
  logic signed [S_WIDTH-1:0]  y_prev_d [CHANNELS];
  logic signed [S_WIDTH-1:0]  tmp_q    [CHANNELS];
  logic signed [S_WIDTH-1:0]  tmp_d    [CHANNELS];

  logic signed [W_WIDTH:0]    wre2;
  logic signed [PW-1:0]       prime_sum [CHANNELS];
  logic signed [PW-1:0]       rec_prod  [CHANNELS];
  logic signed [S_WIDTH-1:0]  prime_res [CHANNELS];
  logic signed [S_WIDTH-1:0]  rec_res   [CHANNELS];
  logic signed [YW-1:0]       xs        [CHANNELS];

  // Datapath: full-width products, sum before the shift, then wrap to S_WIDTH.
  always_comb begin
    wre2 = {wre_q, 1'b0};
    x    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      prime_sum[i] = PW'(y_cur_q[i]) * PW'(wre_q) + PW'(tmp_q[i]) * PW'(wim_q);
      rec_prod[i]  = PW'(y_cur_q[i]) * PW'(wre2);
      prime_res[i] = S_WIDTH'(prime_sum[i] >>> WF);
      rec_res[i]   = S_WIDTH'(rec_prod[i] >>> WF) - y_prev_q[i];
      xs[i]        = YW'(y_cur_q[i] >>> WF);
      if (xs[i] > XMAX) begin
        x[i*X_WIDTH +: X_WIDTH] = XMAX[X_WIDTH-1:0];
      end else if (xs[i] < XMIN) begin
        x[i*X_WIDTH +: X_WIDTH] = XMIN[X_WIDTH-1:0];
      end else begin
        x[i*X_WIDTH +: X_WIDTH] = xs[i][X_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wre_d    = wre_q;
    wim_d    = wim_q;
    y_cur_d  = y_cur_q;
    y_prev_d = y_prev_q;
    tmp_d    = tmp_q;
    ready_o  = rstn && (state_q == IDLE);
    valid_o  = (state_q == RUN);
    last_o   = valid_o && (cnt_q == CW'(FRAME_LENGTH - 1));

    case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          wre_d = w_re;
          wim_d = w_im;
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            y_cur_d[i] = re[i*S_WIDTH +: S_WIDTH];
            tmp_d[i]   = im[i*S_WIDTH +: S_WIDTH];
          end
          cnt_d   = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          y_prev_d[i] = prime_res[i];
        end
        state_d = RUN;
      end
      RUN: begin
        if (ready_i) begin
          // The final handshake leaves the state frozen so x stays on the last sample.
          if (last_o) begin
            state_d = IDLE;
          end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
              y_cur_d[i]  = rec_res[i];
              y_prev_d[i] = y_cur_q[i];
            end
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wre_q    <= '0;
      wim_q    <= '0;
      y_cur_q  <= '{default: '0};
      y_prev_q <= '{default: '0};
      tmp_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wre_q    <= wre_d;
      wim_q    <= wim_d;
      y_cur_q  <= y_cur_d;
      y_prev_q <= y_prev_d;
      tmp_q    <= tmp_d;
    end
  end

endmodule

// File: tb/tb_serial_tone_synth.sv
// Directed bench for serial_tone_synth: expected samples are queued at load time and
// compared by a monitor on every output handshake.
module tb_serial_tone_synth;

  localparam int FL = 4;
  localparam int CH = 2;
  localparam int SW = 32;
  localparam int XW = 16;
  localparam int WW = 16;

  logic              clk;
  logic              rstn;
  logic [WW-1:0]     w_re, w_im;
  logic              valid_i, ready_o;
  logic [CH*SW-1:0]  re, im;
  logic [CH*XW-1:0]  x;
  logic              valid_o, ready_i, last_o;

  serial_tone_synth #(
    .W_WIDTH(WW), .X_WIDTH(XW), .S_WIDTH(SW), .WF(10),
    .FRAME_LENGTH(FL), .CHANNELS(CH)
  ) dut (
    .clk(clk), .rstn(rstn), .w_re(w_re), .w_im(w_im),
    .valid_i(valid_i), .ready_o(ready_o), .re(re), .im(im),
    .x(x), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int e0;
    int e1;
    bit last;
  } exp_t;

  exp_t q[$];
  int   tbl[6][FL];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic push_frame(input int r0, input int r1);
    exp_t e;
    for (int k = 0; k < FL; k++) begin
      e.e0   = tbl[r0][k];
      e.e1   = tbl[r1][k];
      e.last = (k == FL - 1);
      q.push_back(e);
    end
  endtask

  // Scoreboard monitor: one pop per output handshake.
  always @(negedge clk) begin
    if (last_o) chk_bit("last_without_valid", valid_o, 1'b1);
    if (rstn && valid_o && ready_i) begin
      if (q.size() == 0) begin
        chk_bit("unexpected_sample", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("x_ch0", $signed(x[XW-1:0]), e.e0);
        chk("x_ch1", $signed(x[2*XW-1:XW]), e.e1);
        chk_bit("last_o", last_o, e.last);
      end
    end
  end

  task automatic drive(input logic signed [31:0] r0, input logic signed [31:0] i0,
                       input logic signed [31:0] r1, input logic signed [31:0] i1,
                       input logic signed [15:0] wr, input logic signed [15:0] wi);
    re   = {r1, r0};
    im   = {i1, i0};
    w_re = wr;
    w_im = wi;
  endtask

  // Returns #1 after the accepting edge; afterwards scrambles inputs to prove they were latched.
  task automatic load(input logic signed [31:0] r0, input logic signed [31:0] i0,
                      input logic signed [31:0] r1, input logic signed [31:0] i1,
                      input logic signed [15:0] wr, input logic signed [15:0] wi);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    drive(r0, i0, r1, i1, wr, wi);
    valid_i = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      if (ready_o) acc = 1'b1;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    re   = {$urandom, $urandom};
    im   = {$urandom, $urandom};
    w_re = WW'($urandom);
    w_im = WW'($urandom);
    chk_bit("load_accept", acc, 1'b1);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk); #1;
      if (q.size() == 0) ok = 1'b1;
    end
    chk_bit("drain_timeout", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    tbl[0] = '{100, 0, -100, 0};
    tbl[1] = '{0, -50, 0, 50};
    tbl[2] = '{7, 7, 7, 7};
    tbl[3] = '{-7, -7, -7, -7};
    tbl[4] = '{32767, 32767, 32767, 32767};
    tbl[5] = '{-32768, -32768, -32768, -32768};

    rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Reset
    @(posedge clk);
    @(negedge clk);
    chk_bit("ready_in_reset", ready_o, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_bit("rst_ready", ready_o, 1'b1);
    chk_bit("rst_valid", valid_o, 1'b0);
    chk_bit("rst_last", last_o, 1'b0);
    chk("rst_x", $signed(x), 0);

    // Quarter-wave: ch0 cosine, ch1 sine
    load(102400, 0, 0, 51200, 0, 1024);
    push_frame(0, 1);
    @(negedge clk);
    chk_bit("prime_valid", valid_o, 1'b0);
    chk_bit("prime_ready", ready_o, 1'b0);
    @(negedge clk);
    chk_bit("lat_valid", valid_o, 1'b1);
    wait_drain();
    @(negedge clk);
    chk_bit("ready_after_frame", ready_o, 1'b1);
    chk_bit("valid_after_frame", valid_o, 1'b0);

    // DC and saturation
    load(7168, 0, -7168, 0, 1024, 0);
    push_frame(2, 3);
    wait_drain();
    load(40960000, 0, -40960000, 0, 1024, 0);
    push_frame(4, 5);
    wait_drain();

    // Backpressure while sample 1 is presented
    load(102400, 0, 0, 51200, 0, 1024);
    push_frame(0, 1);
    @(posedge clk);
    @(posedge clk); #1;
    ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_bit("bp_valid", valid_o, 1'b1);
      chk_bit("bp_last", last_o, 1'b0);
      chk("bp_x0", $signed(x[XW-1:0]), 0);
      chk("bp_x1", $signed(x[2*XW-1:XW]), -50);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    wait_drain();

    // valid_i pulse during RUN is ignored
    load(102400, 0, 0, 51200, 0, 1024);
    push_frame(0, 1);
    @(posedge clk); #1;
    drive(7168, 0, 7168, 0, 1024, 0);
    valid_i = 1'b1;
    @(negedge clk);
    chk_bit("run_ready", ready_o, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_drain();
    repeat (3) begin
      @(negedge clk);
      chk_bit("no_extra_frame", valid_o, 1'b0);
    end

    // Back-to-back loads with valid_i held high
    @(posedge clk); #1;
    drive(102400, 0, 0, 51200, 0, 1024);
    valid_i = 1'b1;
    push_frame(0, 1);
    push_frame(0, 1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (valid_o && ready_i && last_o) found = 1'b1;
    end
    chk_bit("b2b_first_last", found, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_bit("b2b_idle_ready", ready_o, 1'b1);
    chk_bit("b2b_idle_valid", valid_o, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk_bit("b2b_prime", valid_o, 1'b0);
    @(negedge clk);
    chk_bit("b2b_first", valid_o, 1'b1);
    wait_drain();

    // Reset mid-frame after sample 1
    load(102400, 0, 0, 51200, 0, 1024);
    push_frame(0, 1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    ready_i = 1'b0;
    @(negedge clk);
    chk_bit("rst_mid_ready_low", ready_o, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    ready_i = 1'b1;
    q.delete();
    @(negedge clk);
    chk_bit("rst_mid_valid", valid_o, 1'b0);
    chk_bit("rst_mid_ready", ready_o, 1'b1);
    chk_bit("rst_mid_last", last_o, 1'b0);
    chk("rst_mid_x", $signed(x), 0);
    repeat (2) begin
      @(negedge clk);
      chk_bit("rst_mid_no_valid", valid_o, 1'b0);
    end
    load(102400, 0, 0, 51200, 0, 1024);
    push_frame(0, 1);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
